cr_kme_fifo_pack_writer: RTL and testbench
==========================================

Name: cr_kme_fifo_pack_writer

Overview:
- Producer side of the KME 132-bit stall-flow-controlled FIFO.
- Accepts a 32-bit word stream with sop/eop framing and packs 4 words into one 132-bit entry: 128 data bits plus 4 sideband bits.
- Writes each entry into the FIFO write port (fifo_in/fifo_in_valid) and never writes while fifo_in_stall is high.
- Sits between the KME key/command parsers and the KME staging FIFO.

Parameters:
- IN_W, 32, input word width; IN_W*N_WORDS must equal 128.
- N_WORDS, 4, words per FIFO entry; fixed at 4 because the sideband count field is 2 bits.
- FLUSH_TO, 16, idle cycles after which a partial non-eop entry is force-flushed; 0 disables the flush.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  32  stream word.
- in_sop  input  1  first word of frame.
- in_eop  input  1  last word of frame.
- in_valid  input  1  word present.
- in_ready  output  1  word accepted this cycle when in_valid&in_ready.
- fifo_in  output  132  entry: [127:0] data, word k at [32k+31:32k]; [129:128] valid-word-count minus 1; [130] eop; [131] sop.
- fifo_in_valid  output  1  FIFO write strobe.
- fifo_in_stall  input  1  FIFO has no free slot.
- proto_err  output  1  one-cycle pulse on a framing violation.
- entry_cnt  output  16  entries written since reset; wraps.

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-high on rst. Sampled high at a clk edge, it clears all state:
  - state=EMPTY, word index=0, pack buffer=0, flush counter=0.
  - fifo_in_valid=0, fifo_in=0, proto_err=0, entry_cnt=0, in_ready=0 during the reset cycle.
  - Reset mid-frame discards the partial entry and nothing is written.
- States:
  - EMPTY: no words held.
  - FILL: 1..3 words held.
  - PEND: complete entry registered, awaiting write.
- Packing:
  - An accepted word is stored at slot idx; idx increments.
  - sop is latched from the first word of the entry.
  - The entry closes on idx reaching 3 with a word accepted, or on in_eop.
  - Closing moves it to PEND with count=idx, eop=in_eop.
  - Unused data slots are zero.
- Write rules:
  - fifo_in_valid = (state==PEND) & ~fifo_in_stall. This is combinational from the registered state and stall.
  - fifo_in is a registered value, stable throughout PEND.
  - A write completes in the cycle fifo_in_valid=1, returns state to EMPTY, and increments entry_cnt.
- in_ready = (state!=PEND) | ~fifo_in_stall.
  - In PEND with stall low, the write and a new accepted word occur in the same cycle. That word starts a new entry at idx 0 (state FILL, or PEND if it carries eop).
  - Sustained throughput is 1 word/cycle while stall is low.
- Latency: the entry is presented on the cycle after the closing word is accepted; earliest write is that cycle.
- Flush timeout:
  - In FILL, the counter increments on each cycle with no accepted word and clears on an accepted word.
  - On reaching FLUSH_TO, the partial entry moves to PEND with eop=0 and count=idx-1.
  - The frame continues in the next entry, with sop=0.
- Framing errors (proto_err pulses the cycle after the offending word is accepted):
  - in_sop accepted while in FILL: the word is treated as a continuation, and sop is not set mid-entry.
  - First word of a frame without in_sop: the word is still packed.
  - in_sop&in_eop on one word is legal: single-word entry, count=0.
- Stall held high indefinitely: hold PEND and fifo_in unchanged, in_ready=0, no write.
- The block never asserts fifo_in_valid while fifo_in_stall=1, so FIFO overflow is impossible by construction.

Decomposition:
- Package cr_kme_pack_pkg holds:
  - the entry field offsets (SOP_BIT=131, EOP_BIT=130, CNT_LSB=128);
  - the state enum {EMPTY, FILL, PEND};
  - the 132-bit entry typedef.
- One sub-module is natural: cr_kme_pack_flush_timer, the idle counter and timeout compare.

Test Plan:
- 8-word frame 0x1..0x8 (sop on 0x1, eop on 0x8), stall=0 -> two writes:
  - first {sop=1, eop=0, cnt=3, data=0x4_3_2_1};
  - second {sop=0, eop=1, cnt=3, data 0x8_7_6_5};
  - entry_cnt=2; in_ready never low.
- 3-word frame A,B,C with eop on C -> one write {sop=1, eop=1, cnt=2, [127:96]=0, [95:0]=C,B,A}.
- Entry completes while stall=1 for 10 cycles -> fifo_in_valid=0 and in_ready=0 throughout with fifo_in stable; write occurs the first cycle stall=0, with a next word accepted in that same cycle.
- 2 words then 16 idle cycles (FLUSH_TO=16) -> write {eop=0, cnt=1}; next word starts a new entry with sop=0.
- in_sop on the 2nd word of an entry -> proto_err single pulse; packed data unchanged; sop bit remains from the first word.
- rst asserted after 2 words of a frame -> no write, entry_cnt=0; a subsequent 4-word frame writes one clean entry.

Source files
------------

// File: rtl/cr_kme_pack_pkg.sv
// Shared definitions for the KME FIFO pack writer.
// Contents:
//   - entry layout constants (data field, word-count field, eop and sop bits)
//   - pack_state_e : pack buffer state (EMPTY / FILL / PEND)
//   - entry_t      : one 132-bit FIFO entry
package cr_kme_pack_pkg;

  localparam int ENTRY_W = 132;
  localparam int DATA_W  = 128;
  localparam int SOP_BIT = 131;
  localparam int EOP_BIT = 130;
  localparam int CNT_LSB = 128;
  localparam int CNT_W   = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no words held
    FILL  = 2'd1,  // 1..3 words held
    PEND  = 2'd2   // complete entry registered, waiting for a FIFO slot
  } pack_state_e;

  typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/cr_kme_pack_flush_timer.sv
// Idle counter for a partially filled entry.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   active   : a partial entry is held (state FILL)
//   hit      : a word is accepted this cycle
//   expire   : this idle cycle is the FLUSH_TO-th one in a row; the partial
//              entry should be closed at the coming edge
// FLUSH_TO = 0 disables the timeout entirely.
module cr_kme_pack_flush_timer #(
  parameter int FLUSH_TO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic hit,
  output logic expire
);

  localparam int CW = (FLUSH_TO > 1) ? $clog2(FLUSH_TO) : 1;

  logic [CW-1:0] cnt;

  // cnt holds the number of idle cycles already seen, so the FLUSH_TO-th
  // idle cycle is the one that finds cnt at FLUSH_TO-1.
  assign expire = (FLUSH_TO != 0) && active && !hit && (cnt == CW'(FLUSH_TO - 1));

  always_ff @(posedge clk) begin
    if (rst || !active || hit || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cr_kme_fifo_pack_writer.sv
// Producer side of the KME 132-bit stall-flow-controlled FIFO.
// Packs a framed 32-bit word stream into 4-word entries and writes them into
// the FIFO write port.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   in_data/in_sop/in_eop/in_valid, in_ready : input word stream
//   fifo_in, fifo_in_valid : FIFO write data and write strobe
//   fifo_in_stall  : FIFO has no free slot
//   proto_err      : one-cycle pulse, the cycle after a badly framed word
//   entry_cnt      : entries written since reset (wraps)
// Handshake: a word transfers on a clk edge where in_valid & in_ready are
// both high; an entry is written on a clk edge where fifo_in_valid is high,
// and fifo_in_valid is never high while fifo_in_stall is high.
module cr_kme_fifo_pack_writer
  import cr_kme_pack_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int N_WORDS  = 4,
  parameter int FLUSH_TO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ENTRY_W-1:0] fifo_in,
  output logic              fifo_in_valid,
  input  logic              fifo_in_stall,
  output logic              proto_err,
  output logic [15:0]       entry_cnt
);

  pack_state_e      state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, base_idx;
  entry_t           ent_q, ent_d;
  logic             in_frame_q, in_frame_d;
  logic             err_d;
  logic             accept, write, flush_expire;

  assign write         = (state_q == PEND) && !fifo_in_stall;
  assign fifo_in_valid = write;
  assign in_ready      = !rst && ((state_q != PEND) || !fifo_in_stall);
  assign accept        = in_valid && in_ready;
  // The pack register doubles as the write data, so it is stable in PEND.
  assign fifo_in       = ent_q;

  cr_kme_pack_flush_timer #(.FLUSH_TO(FLUSH_TO)) u_flush_timer (
    .clk    (clk),
    .rst    (rst),
    .active (state_q == FILL),
    .hit    (accept),
    .expire (flush_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    in_frame_d = in_frame_q;
    err_d      = 1'b0;
    // A word accepted in PEND rides along with the write, so it opens a new
    // entry exactly like a word arriving in EMPTY.
    base_idx   = (state_q == FILL) ? idx_q : '0;
    if (accept) begin
      if (base_idx == '0) begin
        ent_d          = '0;
        ent_d[SOP_BIT] = in_sop;
      end
      ent_d[int'(base_idx)*IN_W +: IN_W] = in_data;
      // sop inside an entry, or a frame opening without sop.
      err_d      = (state_q == FILL) ? in_sop : (!in_frame_q && !in_sop);
      in_frame_d = !in_eop;
      if (in_eop || base_idx == CNT_W'(N_WORDS - 1)) begin
        state_d                  = PEND;
        idx_d                    = '0;
        ent_d[EOP_BIT]           = in_eop;
        ent_d[CNT_LSB +: CNT_W]  = base_idx;
      end else begin
        state_d = FILL;
        idx_d   = base_idx + 1'b1;
      end
    end else if (flush_expire) begin
      // Frame stays open; its next word starts a fresh entry with sop=0.
      state_d                 = PEND;
      idx_d                   = '0;
      ent_d[EOP_BIT]          = 1'b0;
      ent_d[CNT_LSB +: CNT_W] = idx_q - 1'b1;
    end else if (write) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      idx_q      <= '0;
      ent_q      <= '0;
      in_frame_q <= 1'b0;
      proto_err  <= 1'b0;
      entry_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      in_frame_q <= in_frame_d;
      proto_err  <= err_d;
      entry_cnt  <= entry_cnt + 16'(write);
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_pack_writer.sv
// Testbench for cr_kme_fifo_pack_writer.
module tb_cr_kme_fifo_pack_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [131:0] fifo_in;
  logic         fifo_in_valid;
  logic         fifo_in_stall = 1'b0;
  logic         proto_err;
  logic [15:0]  entry_cnt;

  cr_kme_fifo_pack_writer dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fifo_in       (fifo_in),
    .fifo_in_valid (fifo_in_valid),
    .fifo_in_stall (fifo_in_stall),
    .proto_err     (proto_err),
    .entry_cnt     (entry_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           fails = 0;
  logic [131:0] exp_q[$];
  int           exp_since_rst = 0;
  int           err_pulses = 0;

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [131:0] e);
    exp_q.push_back(e);
    exp_since_rst++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (proto_err === 1'b1) err_pulses++;
      if (fifo_in_valid !== 1'b0) begin
        check("no_write_under_stall", {131'b0, fifo_in_stall}, 132'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got %h expected no write", fifo_in);
        end else begin
          check("entry", fifo_in, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic s, input logic e, output int waited);
    waited = 0;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d entries outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           n;
    logic [31:0]  base;
    logic         sop;
    logic         eop;
    logic [131:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w;
    int total_wait;
    int lat;
    int e0;

    vecs[0] = '{1, 32'h000000A0, 1'b1, 1'b1, {1'b1, 1'b1, 2'd0, 96'h0, 32'h000000A0}};
    vecs[1] = '{3, 32'h000000C1, 1'b1, 1'b1, {1'b1, 1'b1, 2'd2, 32'h0, 32'hC3, 32'hC2, 32'hC1}};
    vecs[2] = '{4, 32'h00000100, 1'b1, 1'b1, {1'b1, 1'b1, 2'd3, 32'h103, 32'h102, 32'h101, 32'h100}};
    vecs[3] = '{2, 32'hDEAD0000, 1'b1, 1'b1, {1'b1, 1'b1, 2'd1, 64'h0, 32'hDEAD0001, 32'hDEAD0000}};
    vecs[4] = '{4, 32'h00000055, 1'b1, 1'b0, {1'b1, 1'b0, 2'd3, 32'h58, 32'h57, 32'h56, 32'h55}};
    vecs[5] = '{2, 32'h00000077, 1'b0, 1'b1, {1'b0, 1'b1, 2'd1, 64'h0, 32'h78, 32'h77}};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_in_valid", {131'b0, fifo_in_valid}, 132'd0);
    check("rst_fifo_in", fifo_in, 132'd0);
    check("rst_proto_err", {131'b0, proto_err}, 132'd0);
    check("rst_entry_cnt", {116'b0, entry_cnt}, 132'd0);
    check("rst_in_ready", {131'b0, in_ready}, 132'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_since_rst = 0;

    // 8-word frame, two full entries, no back-pressure
    expect_entry({1'b1, 1'b0, 2'd3, 32'h4, 32'h3, 32'h2, 32'h1});
    expect_entry({1'b0, 1'b1, 2'd3, 32'h8, 32'h7, 32'h6, 32'h5});
    total_wait = 0;
    for (int i = 1; i <= 8; i++) begin
      send_word(32'(i), i == 1, i == 8, w);
      total_wait += w;
    end
    check("in_ready_never_low", 132'(total_wait), 132'd0);
    drain();
    check("entry_cnt_8word", {116'b0, entry_cnt}, 132'(exp_since_rst));

    // Table of single-entry shapes
    for (int v = 0; v < 6; v++) begin
      expect_entry(vecs[v].exp);
      for (int i = 0; i < vecs[v].n; i++) begin
        send_word(vecs[v].base + 32'(i), (i == 0) && vecs[v].sop,
                  (i == vecs[v].n - 1) && vecs[v].eop, w);
      end
    end
    drain();
    check("entry_cnt_table", {116'b0, entry_cnt}, 132'(exp_since_rst));

    // Entry completes under stall; write and next word in the same cycle
    fifo_in_stall = 1'b1;
    expect_entry({1'b1, 1'b1, 2'd3, 32'h14, 32'h13, 32'h12, 32'h11});
    for (int i = 0; i < 4; i++) send_word(32'h11 + 32'(i), i == 0, i == 3, w);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid_low", {131'b0, fifo_in_valid}, 132'd0);
      check("stall_ready_low", {131'b0, in_ready}, 132'd0);
      check("stall_fifo_in_stable", fifo_in, {1'b1, 1'b1, 2'd3, 32'h14, 32'h13, 32'h12, 32'h11});
    end
    @(posedge clk);
    #1;
    fifo_in_stall = 1'b0;
    expect_entry({1'b1, 1'b1, 2'd0, 96'h0, 32'h99});
    in_data  = 32'h99;
    in_sop   = 1'b1;
    in_eop   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("unstall_write", {131'b0, fifo_in_valid}, 132'd1);
    check("unstall_ready", {131'b0, in_ready}, 132'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    drain();

    // Flush timeout on a 2-word partial entry
    expect_entry({1'b1, 1'b0, 2'd1, 64'h0, 32'h22, 32'h21});
    send_word(32'h21, 1'b1, 1'b0, w);
    send_word(32'h22, 1'b0, 1'b0, w);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fifo_in_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("flush_latency", 132'(lat), 132'd17);
    @(posedge clk);
    #1;
    e0 = err_pulses;
    expect_entry({1'b0, 1'b1, 2'd0, 96'h0, 32'h23});
    send_word(32'h23, 1'b0, 1'b1, w);
    drain();
    check("flush_continuation_no_err", 132'(err_pulses - e0), 132'd0);

    // sop on the second word of an entry
    e0 = err_pulses;
    expect_entry({1'b1, 1'b1, 2'd3, 32'h34, 32'h33, 32'h32, 32'h31});
    send_word(32'h31, 1'b1, 1'b0, w);
    send_word(32'h32, 1'b1, 1'b0, w);
    send_word(32'h33, 1'b0, 1'b0, w);
    send_word(32'h34, 1'b0, 1'b1, w);
    drain();
    check("err_mid_sop_pulses", 132'(err_pulses - e0), 132'd1);

    // Frame opening without sop
    e0 = err_pulses;
    expect_entry({1'b0, 1'b1, 2'd0, 96'h0, 32'h41});
    send_word(32'h41, 1'b0, 1'b1, w);
    drain();
    check("err_missing_sop_pulses", 132'(err_pulses - e0), 132'd1);

    // Reset mid-frame drops the partial entry
    send_word(32'h51, 1'b1, 1'b0, w);
    send_word(32'h52, 1'b0, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", {131'b0, in_ready}, 132'd0);
    check("midrst_valid", {131'b0, fifo_in_valid}, 132'd0);
    check("midrst_fifo_in", fifo_in, 132'd0);
    check("midrst_entry_cnt", {116'b0, entry_cnt}, 132'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_since_rst = 0;
    expect_entry({1'b1, 1'b1, 2'd3, 32'h64, 32'h63, 32'h62, 32'h61});
    for (int i = 0; i < 4; i++) send_word(32'h61 + 32'(i), i == 0, i == 3, w);
    drain();
    check("post_rst_entry_cnt", {116'b0, entry_cnt}, 132'(exp_since_rst));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
